// File: rtl/corr_acc_bank.sv
// Lag-accumulator bank: each sync pulse adds dsample*dshift[j] into bin j through a
// read-modify-write pipeline over a 1R1W block RAM, with a host read port and sticky flags.
module corr_acc_bank #(
  parameter int unsigned NLags    = 512,
  parameter int unsigned Aw       = 9,
  parameter int unsigned Dw       = 8,
  parameter int unsigned AccW     = 32,
  parameter int unsigned LagDelay = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            sin_i,
  input  logic [Dw-1:0]   dsample_i,
  input  logic [Dw-1:0]   dshift_i,
  input  logic            rd_en_i,
  input  logic [Aw-1:0]   rd_addr_i,
  output logic [AccW-1:0] rd_data_o,
  output logic            rd_valid_o,
  output logic [31:0]     n_samples_o,
  output logic            busy_o,
  output logic            ovf_o,
  output logic            drop_o
);

  localparam int unsigned SumW    = AccW + 1;
  localparam logic [Aw-1:0] LastIdx = Aw'(NLags - 1);

  typedef enum logic [2:0] {StIdle, StWait, StAcc, StDrain, StClr} state_e;

  state_e          state_q;
  logic [Aw-1:0]   idx_q;
  logic [15:0]     wait_q;
  logic            clr_pend_q, drop_q, ovf_q;
  logic [31:0]     n_samples_q;

  logic            s1_valid_q, s2_valid_q;
  logic [Aw-1:0]   s1_addr_q, s2_addr_q;
  logic [2*Dw-1:0] prod_q;
  logic [AccW-1:0] s2_data_q;
  logic [AccW-1:0] ram_rdata_q;
  logic            rd_pend_q, rd_valid_q;
  logic [AccW-1:0] rd_data_q;

  logic [AccW-1:0] mem [NLags];

  logic            sin_go, s0_fire, rd_go, sat, we;
  logic [Aw-1:0]   s0_addr, raddr, waddr;
  logic [SumW-1:0] sum_ext;
  logic [AccW-1:0] sum, wdata;

  assign sin_go  = (state_q == StIdle) && sin_i && !clr_i;
  assign s0_fire = (state_q == StAcc) || (sin_go && (LagDelay == 0));
  assign s0_addr = (state_q == StAcc) ? idx_q : '0;
  // A burst starting with zero lag delay owns the read port in its sin cycle.
  assign rd_go   = rd_en_i && (state_q == StIdle) && !s0_fire;
  assign raddr   = s0_fire ? s0_addr : rd_addr_i;

  assign sum_ext = {1'b0, ram_rdata_q} + SumW'(prod_q);
  assign sat     = sum_ext[AccW];
  assign sum     = sat ? '1 : sum_ext[AccW-1:0];

  assign we      = (state_q == StClr) || s2_valid_q;
  assign waddr   = (state_q == StClr) ? idx_q : s2_addr_q;
  assign wdata   = (state_q == StClr) ? '0 : s2_data_q;

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    ram_rdata_q <= mem[raddr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s0_fire;
      s1_addr_q  <= s0_addr;
      prod_q     <= dsample_i * dshift_i;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= sum;
      rd_pend_q  <= rd_go;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= ram_rdata_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wait_q      <= '0;
      clr_pend_q  <= 1'b0;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      n_samples_q <= '0;
    end else begin
      if (sin_i && (state_q != StIdle)) begin
        drop_q <= 1'b1;
      end
      if (s1_valid_q && sat) begin
        ovf_q <= 1'b1;
      end
      if (clr_i && (state_q inside {StWait, StAcc, StDrain})) begin
        clr_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (clr_i) begin
            state_q <= StClr;
            idx_q   <= '0;
          end else if (sin_i) begin
            if (LagDelay == 0) begin
              state_q <= StAcc;
              idx_q   <= Aw'(1);
            end else if (LagDelay == 1) begin
              state_q <= StAcc;
              idx_q   <= '0;
            end else begin
              state_q <= StWait;
              idx_q   <= '0;
              wait_q  <= '0;
            end
          end
        end
        StWait: begin
          if (wait_q == 16'(LagDelay - 2)) begin
            state_q <= StAcc;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        StAcc: begin
          if (idx_q == LastIdx) begin
            state_q <= StDrain;
            wait_q  <= '0;
          end else begin
            idx_q <= idx_q + Aw'(1);
          end
        end
        StDrain: begin
          if (wait_q == 16'd1) begin
            n_samples_q <= n_samples_q + 32'd1;
            if (clr_pend_q || clr_i) begin
              state_q    <= StClr;
              idx_q      <= '0;
              clr_pend_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        StClr: begin
          if (idx_q == LastIdx) begin
            state_q     <= StIdle;
            n_samples_q <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
          end else begin
            idx_q <= idx_q + Aw'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign n_samples_o = n_samples_q;
  assign ovf_o       = ovf_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_corr_acc_bank.sv
// Bench for corr_acc_bank: a 32-bit and a 17-bit accumulator build share one stimulus stream;
// host reads push expectations into queues that a negedge monitor pops on rd_valid.
module tb_corr_acc_bank;

  localparam int NLAGS = 512;
  localparam logic [63:0] SAT17 = 64'd131071;

  logic        clk, rst_n, clr, sin, rd_en;
  logic [7:0]  dsample, dshift;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data32, ns32, ns17;
  logic [16:0] rd_data17;
  logic        rd_valid32, rd_valid17, busy32, busy17, ovf32, ovf17, drop32, drop17;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int last_sin = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t q32[$];
  exp_t q17[$];

  corr_acc_bank dut32 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .sin_i(sin), .dsample_i(dsample),
    .dshift_i(dshift), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data32),
    .rd_valid_o(rd_valid32), .n_samples_o(ns32), .busy_o(busy32), .ovf_o(ovf32),
    .drop_o(drop32)
  );

  corr_acc_bank #(.AccW(17)) dut17 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .sin_i(sin), .dsample_i(dsample),
    .dshift_i(dshift), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data17),
    .rd_valid_o(rd_valid17), .n_samples_o(ns17), .busy_o(busy17), .ovf_o(ovf17),
    .drop_o(drop17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid32) begin
      if (q32.size() == 0) begin
        chk("rd32_unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk("rd32_data", {32'd0, rd_data32}, e.data);
        chk("rd32_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rd_valid17) begin
      if (q17.size() == 0) begin
        chk("rd17_unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q17.pop_front();
        chk("rd17_data", {47'd0, rd_data17}, e.data);
        chk("rd17_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound, output int end_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy32 || busy17) && n < bound) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    chk("idle_timeout32", {63'd0, busy32}, 64'd0);
    chk("idle_timeout17", {63'd0, busy17}, 64'd0);
    tick();
  endtask

  task automatic do_clr();
    int e;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_next_cycle", {63'd0, busy32}, 64'd1);
    wait_idle(NLAGS + 20, e);
  endtask

  // ff_pat: dshift=255 else j&255; extra_* inject an event at burst cycle j (-1: none).
  task automatic burst(input logic [7:0] ds, input logic ff_pat, input int extra_sin,
                       input int extra_clr, input int extra_rd, input int len);
    for (int j = 0; j < len; j++) begin
      sin     = (j == 0) || (j == extra_sin);
      clr     = (j == extra_clr);
      rd_en   = (j == extra_rd);
      rd_addr = 9'd7;
      dsample = ds;
      dshift  = ff_pat ? 8'hff : 8'(j & 255);
      if (j == 0) last_sin = cyc;
      tick();
    end
    sin    = 1'b0;
    clr    = 1'b0;
    rd_en  = 1'b0;
    dshift = 8'd0;
  endtask

  task automatic read_all(input logic [63:0] k, input logic [63:0] c);
    logic [63:0] v;
    for (int j = 0; j < NLAGS; j++) begin
      v       = k * 64'(j & 255) + c;
      rd_en   = 1'b1;
      rd_addr = 9'(j);
      q32.push_back('{v, cyc + 2});
      q17.push_back('{(v > SAT17) ? SAT17 : v, cyc + 2});
      tick();
    end
    rd_en = 1'b0;
    repeat (4) tick();
    chk("rd32_outstanding", 64'(q32.size()), 64'd0);
    chk("rd17_outstanding", 64'(q17.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    rst_n = 1'b0; clr = 1'b0; sin = 1'b0; rd_en = 1'b0;
    dsample = 8'd0; dshift = 8'd0; rd_addr = 9'd0;
    repeat (3) tick();
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_n_samples", {32'd0, ns32}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid32}, 64'd0);
    chk("rst_ovf", {63'd0, ovf32}, 64'd0);
    chk("rst_drop", {63'd0, drop17}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: clear after reset, every bin reads zero
    do_clr();
    read_all(64'd0, 64'd0);
    chk("t1_n_samples", {32'd0, ns32}, 64'd0);
    chk("t1_ovf", {63'd0, ovf32}, 64'd0);
    chk("t1_drop", {63'd0, drop32}, 64'd0);

    // T2: single ramp burst, bin j = 3*(j&255)
    burst(8'd3, 1'b0, -1, -1, -1, NLAGS);
    wait_idle(20, e);
    chk("t2_busy_len", 64'(e - last_sin), 64'(NLAGS + 2));
    chk("t2_n_samples", {32'd0, ns32}, 64'd1);
    chk("t2_n_samples17", {32'd0, ns17}, 64'd1);
    read_all(64'd3, 64'd0);

    // T3/T4: three full-scale bursts; 17-bit build saturates on the third
    do_clr();
    burst(8'd255, 1'b1, -1, -1, -1, NLAGS);
    wait_idle(20, e);
    burst(8'd255, 1'b1, -1, -1, -1, NLAGS);
    wait_idle(20, e);
    chk("t4_ovf17_after2", {63'd0, ovf17}, 64'd0);
    chk("t3_n_samples_after2", {32'd0, ns32}, 64'd2);
    burst(8'd255, 1'b1, -1, -1, -1, NLAGS);
    wait_idle(20, e);
    chk("t4_ovf17_after3", {63'd0, ovf17}, 64'd1);
    chk("t3_ovf32", {63'd0, ovf32}, 64'd0);
    chk("t3_n_samples", {32'd0, ns32}, 64'd3);
    read_all(64'd0, 64'd195075);

    // T5: sin and host read while busy are dropped
    do_clr();
    chk("t5_ovf17_cleared", {63'd0, ovf17}, 64'd0);
    burst(8'd3, 1'b0, 100, -1, 200, NLAGS);
    wait_idle(20, e);
    chk("t5_drop32", {63'd0, drop32}, 64'd1);
    chk("t5_drop17", {63'd0, drop17}, 64'd1);
    chk("t5_n_samples", {32'd0, ns32}, 64'd1);
    read_all(64'd3, 64'd0);

    // T6: clr mid-burst is deferred until the burst drains
    do_clr();
    chk("t6_drop_cleared", {63'd0, drop32}, 64'd0);
    burst(8'd3, 1'b0, -1, 50, -1, NLAGS);
    wait_idle(NLAGS + 40, e);
    chk("t6_busy_len", 64'(e - last_sin), 64'(2 * NLAGS + 2));
    chk("t6_n_samples", {32'd0, ns32}, 64'd0);
    read_all(64'd0, 64'd0);

    // Reset mid-burst clears outputs immediately
    burst(8'd3, 1'b0, -1, -1, -1, NLAGS);
    wait_idle(20, e);
    burst(8'd3, 1'b0, 30, -1, -1, 60);
    chk("rst_mid_pre_busy", {63'd0, busy32}, 64'd1);
    chk("rst_mid_pre_drop", {63'd0, drop32}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy32}, 64'd0);
    chk("rst_mid_n_samples", {32'd0, ns32}, 64'd0);
    chk("rst_mid_drop", {63'd0, drop32}, 64'd0);
    chk("rst_mid_busy17", {63'd0, busy17}, 64'd0);
    chk("rst_mid_rd_valid", {63'd0, rd_valid32}, 64'd0);
    repeat (3) tick();
    chk("end_q32_empty", 64'(q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
